// File: rtl/tl_uh_master_arbiter.sv
// Two-requester TileLink-UH master arbiter for the fetch frontend.
// One transaction in flight; grant held from first A beat to last D beat.
module tl_uh_master_arbiter #(
    parameter int MAX_SIZE   = 6,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        core_clock_i,
    input  logic        core_reset_n_i,

    input  logic [2:0]  m0_a_opcode,
    input  logic [2:0]  m0_a_param,
    input  logic [3:0]  m0_a_size,
    input  logic [31:0] m0_a_address,
    input  logic [3:0]  m0_a_mask,
    input  logic [31:0] m0_a_data,
    input  logic        m0_a_corrupt,
    input  logic        m0_a_valid,
    output logic        m0_a_ready,
    output logic [2:0]  m0_d_opcode,
    output logic [1:0]  m0_d_param,
    output logic [3:0]  m0_d_size,
    output logic        m0_d_denied,
    output logic [31:0] m0_d_data,
    output logic        m0_d_corrupt,
    output logic        m0_d_valid,
    input  logic        m0_d_ready,

    input  logic [2:0]  m1_a_opcode,
    input  logic [2:0]  m1_a_param,
    input  logic [3:0]  m1_a_size,
    input  logic [31:0] m1_a_address,
    input  logic [3:0]  m1_a_mask,
    input  logic [31:0] m1_a_data,
    input  logic        m1_a_corrupt,
    input  logic        m1_a_valid,
    output logic        m1_a_ready,
    output logic [2:0]  m1_d_opcode,
    output logic [1:0]  m1_d_param,
    output logic [3:0]  m1_d_size,
    output logic        m1_d_denied,
    output logic [31:0] m1_d_data,
    output logic        m1_d_corrupt,
    output logic        m1_d_valid,
    input  logic        m1_d_ready,

    output logic [2:0]  s_a_opcode,
    output logic [2:0]  s_a_param,
    output logic [3:0]  s_a_size,
    output logic [31:0] s_a_address,
    output logic [3:0]  s_a_mask,
    output logic [31:0] s_a_data,
    output logic        s_a_corrupt,
    output logic        s_a_valid,
    input  logic        s_a_ready,

    input  logic [2:0]  s_d_opcode,
    input  logic [1:0]  s_d_param,
    input  logic [3:0]  s_d_size,
    input  logic        s_d_denied,
    input  logic [31:0] s_d_data,
    input  logic        s_d_corrupt,
    input  logic        s_d_valid,
    output logic        s_d_ready,

    output logic        busy_o
);

    localparam int CW = MAX_SIZE - 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] A_SEND = 2'd1;
    localparam logic [1:0] D_WAIT = 2'd2;

    localparam logic [2:0] ACK_DATA = 3'd1;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] n_q, n_d;
    logic          busy_q, busy_d;

    logic          grant;
    logic          win_data;
    logic [3:0]    win_size;
    logic [3:0]    eff_size;
    logic [CW-1:0] win_n;
    logic          a_phase, d_phase;
    logic          own_a_valid, own_d_ready;
    logic          a_fire, d_fire;

    assign a_phase = (state_q == A_SEND);
    assign d_phase = (state_q == D_WAIT);

    // Last-granted master loses a tie in round-robin mode.
    assign grant = m1_a_valid & (~m0_a_valid | (~FIXED_PRIO & ~last_q));

    // Opcodes 0..3 carry write data and so take N A beats.
    assign win_data = grant ? ~m1_a_opcode[2] : ~m0_a_opcode[2];
    assign win_size = grant ? m1_a_size : m0_a_size;
    assign eff_size = (win_size > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : win_size;
    assign win_n    = (eff_size <= 4'd2) ? CW'(1)
                    : CW'(1) << (eff_size - 4'd2);

    assign s_a_opcode  = owner_q ? m1_a_opcode  : m0_a_opcode;
    assign s_a_param   = owner_q ? m1_a_param   : m0_a_param;
    assign s_a_size    = owner_q ? m1_a_size    : m0_a_size;
    assign s_a_address = owner_q ? m1_a_address : m0_a_address;
    assign s_a_mask    = owner_q ? m1_a_mask    : m0_a_mask;
    assign s_a_data    = owner_q ? m1_a_data    : m0_a_data;
    assign s_a_corrupt = owner_q ? m1_a_corrupt : m0_a_corrupt;

    assign own_a_valid = owner_q ? m1_a_valid : m0_a_valid;
    assign s_a_valid   = a_phase & own_a_valid;
    assign m0_a_ready  = a_phase & ~owner_q & s_a_ready;
    assign m1_a_ready  = a_phase &  owner_q & s_a_ready;

    assign m0_d_opcode  = s_d_opcode;
    assign m0_d_param   = s_d_param;
    assign m0_d_size    = s_d_size;
    assign m0_d_denied  = s_d_denied;
    assign m0_d_data    = s_d_data;
    assign m0_d_corrupt = s_d_corrupt;
    assign m1_d_opcode  = s_d_opcode;
    assign m1_d_param   = s_d_param;
    assign m1_d_size    = s_d_size;
    assign m1_d_denied  = s_d_denied;
    assign m1_d_data    = s_d_data;
    assign m1_d_corrupt = s_d_corrupt;

    assign own_d_ready = owner_q ? m1_d_ready : m0_d_ready;
    assign s_d_ready   = d_phase & own_d_ready;
    assign m0_d_valid  = d_phase & ~owner_q & s_d_valid;
    assign m1_d_valid  = d_phase &  owner_q & s_d_valid;

    assign a_fire = s_a_valid & s_a_ready;
    assign d_fire = s_d_valid & s_d_ready;
    assign busy_o = busy_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (m0_a_valid | m1_a_valid) begin
                    owner_d = grant;
                    data_d  = win_data;
                    n_d     = win_n;
                    cnt_d   = '0;
                    state_d = A_SEND;
                end
            end
            A_SEND: begin
                if (a_fire) begin
                    if (!data_q || cnt_q == n_q - CW'(1)) begin
                        cnt_d   = '0;
                        state_d = D_WAIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            D_WAIT: begin
                if (d_fire) begin
                    if (s_d_opcode != ACK_DATA || cnt_q == n_q - CW'(1)) begin
                        cnt_d   = '0;
                        last_d  = owner_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            data_q  <= 1'b0;
            cnt_q   <= '0;
            n_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            busy_q  <= busy_d;
        end
    end

endmodule
